pci_target_responder: RTL and testbench
=======================================

Name: pci_target_responder

Overview:
- PCI target (slave) side of the bus; it answers transactions started by an initiator that holds GNT and drives FRAME.
- Decodes the address phase and claims hits with DEVSEL.
- Paces data phases with TRDY, and serves single or burst memory reads/writes from a small internal register file.
- Issues target disconnect (STOP) at the top of its window.
- All bus control signals are active-low and held at 1 when idle. AD is split into in/out/enable (no internal tristate).

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base of the decode window; must be aligned to the window size.
- ADDR_WIDTH, 3: word-address bits; the window is 2^ADDR_WIDTH 32-bit words.

Ports:
- CLK  input  1  bus clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- FRAME  input  1  active-low; initiator frame.
- IRDY  input  1  active-low; initiator ready.
- IDSEL  input  1  config select; unused for memory commands, must not affect decode.
- AD_in  input  32  address/write data from the bus.
- CBE  input  4  command during the address phase, active-low byte enables during data phases.
- AD_out  output  32  read data.
- AD_oe  output  1  1 = target drives AD.
- DEVSEL  output  1  active-low device select.
- TRDY  output  1  active-low target ready.
- STOP  output  1  active-low stop/disconnect.

Behaviour:
- **Reset.** RST=1 at a rising edge forces the following, regardless of state, including mid-burst:
  - DEVSEL=1, TRDY=1, STOP=1, AD_oe=0, AD_out=0.
  - State = IDLE; all register-file words = 0.
- **States:** IDLE, BUSY, W_DATA, R_TURN, R_DATA, TURN_AR.
- **Address phase.** In IDLE, an edge with FRAME=0 samples AD_in and CBE. It is a hit when both hold:
  - AD_in[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  - CBE is 4'b0111 (memory write) or 4'b0110 (memory read).
  - On a hit: latch word pointer = AD_in[ADDR_WIDTH+1:2]; AD_in[1:0] is ignored (linear burst only).
  - On a miss: go to BUSY. DEVSEL stays 1 throughout. BUSY returns to IDLE on the first edge with FRAME=1 && IRDY=1.
- **Write hit.**
  - Next state W_DATA; DEVSEL=0 and TRDY=0 are both driven in the cycle after the address phase (medium decode, zero wait states).
  - A data transfer occurs on an edge with IRDY=0 && TRDY=0. On each transfer:
    - byte i of the word at the pointer is written from AD_in[8i+7:8i] only where CBE[i]=0;
    - the pointer then increments.
- **Read hit.**
  - Next state R_TURN: DEVSEL=0, AD_oe=1, TRDY=1 for one turnaround cycle.
  - Then R_DATA with TRDY=0 and AD_out = word at the pointer.
  - AD_out updates to the next word in the same edge that performs a transfer, so back-to-back transfers run with no wait states.
- **Initiator wait states.** IRDY=1 holds the pointer, AD_out and the register file unchanged; TRDY stays 0.
- **Last data phase.**
  - A transfer with FRAME=1 goes to TURN_AR.
  - TURN_AR drives DEVSEL=1, TRDY=1, STOP=1, AD_oe=0 for one cycle, then IDLE.
  - A new FRAME=0 seen in TURN_AR is ignored; the initiator must leave one idle cycle.
- **Disconnect at window top.**
  - When the pointer equals 2^ADDR_WIDTH-1 during a data phase, STOP=0 is asserted together with TRDY=0 (disconnect with data).
  - After that transfer: go to TURN_AR if FRAME=1. If FRAME=0, keep STOP=0, DEVSEL=0, TRDY=1 until FRAME=1, then TURN_AR.
  - The pointer never wraps to 0 within a transaction.
- **Initiator abort.** FRAME=1 && IRDY=1 while in W_DATA, R_TURN or R_DATA goes to TURN_AR with no transfer.
- **Simultaneous RST and transfer.** Reset wins; no register-file write occurs.

Test Plan:
- Single write then read, BASE_ADDR=0:
  - Write: addr 32'h0000_0008, CBE=0111, data 32'hDEAD_BEEF, CBE=0000, FRAME released with IRDY=0 → DEVSEL/TRDY low one cycle after the address phase; word 2 = DEADBEEF.
  - Read: addr 8, CBE=0110 → one turnaround cycle, then AD_oe=1, TRDY=0, AD_out=DEADBEEF.
- Burst write of 4 words at addr 0 (11, 22, 33, 44), IRDY=1 inserted before the third → exactly 4 transfers; words 0..3 = 11,22,33,44; TRDY held 0 during the wait.
- Byte enables: word 2 = DEADBEEF, write 32'h1234_5678 with CBE=1010 → read returns 32'hDE34_BE78.
- Miss: address 32'h0000_0100 (outside the 8-word window), or command CBE=0010 → DEVSEL, TRDY, STOP stay 1 for the whole transaction; memory unchanged.
- Disconnect: burst read from addr 24 (word 6) with FRAME held low → transfers words 6 and 7; STOP=0 with TRDY=0 on word 7; then STOP=0, TRDY=1 until FRAME=1; then one TURN_AR cycle.
- Reset mid-burst: assert RST during the second data phase of a write burst → next edge all outputs deasserted, AD_oe=0, memory all zero; a subsequent valid read of word 0 returns 0.

Source files
------------

// File: rtl/pci_target_responder.sv
// PCI memory target: decodes a 2^ADDR_WIDTH-word window, serves linear single/burst
// reads and writes from an internal register file, and disconnects at the window top.
module pci_target_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME,
    input  logic        IRDY,
    input  logic        IDSEL,
    input  logic [31:0] AD_in,
    input  logic [3:0]  CBE,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        DEVSEL,
    output logic        TRDY,
    output logic        STOP
);

    typedef enum logic [2:0] {
        IDLE, BUSY, W_DATA, R_TURN, R_DATA, TURN_AR
    } state_t;

    localparam int                    WORDS   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_TOP = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                      state;
    state_t                      next_state;
    logic [ADDR_WIDTH-1:0]       ptr;
    logic                        disc;
    logic [WORDS-1:0][31:0]      mem;

    logic addr_match;
    logic cmd_wr;
    logic cmd_rd;
    logic in_data;
    logic at_top;
    logic xfer;
    logic unused_idsel;

    // Memory commands only; configuration select plays no part in decode.
    assign unused_idsel = IDSEL;

    assign addr_match = (AD_in >> (ADDR_WIDTH + 2)) == (BASE_ADDR >> (ADDR_WIDTH + 2));
    assign cmd_wr     = (CBE == 4'b0111);
    assign cmd_rd     = (CBE == 4'b0110);
    assign in_data    = (state == W_DATA) || (state == R_DATA);
    assign at_top     = (ptr == PTR_TOP);
    // disc marks the post-disconnect hold, where TRDY is high and nothing moves.
    assign xfer       = in_data && !disc && !IRDY;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: the register file is reset like any other state, so it must stay in
    // flops; a sync-reset loop over a RAM macro would not map to a real memory.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr  <= '0;
            disc <= 1'b0;
            mem  <= '0;
        end else begin
            if (state == IDLE && !FRAME)
                ptr <= AD_in[ADDR_WIDTH+1:2];
            if (!in_data)
                disc <= 1'b0;
            if (xfer) begin
                if (state == W_DATA) begin
                    for (int b = 0; b < 4; b++)
                        if (!CBE[b]) mem[ptr][8*b +: 8] <= AD_in[8*b +: 8];
                end
                // The pointer parks at the top; the burst is cut rather than wrapped.
                if (at_top) disc <= !FRAME;
                else        ptr  <= ptr + PTR_ONE;
            end
        end
    end

    // NOTE: next_state and every output get a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!FRAME)
                         next_state = (addr_match && cmd_wr) ? W_DATA :
                                      (addr_match && cmd_rd) ? R_TURN : BUSY;
            BUSY:    if (FRAME && IRDY) next_state = IDLE;
            R_TURN:  next_state = (FRAME && IRDY) ? TURN_AR : R_DATA;
            // FRAME high ends the data phase: last transfer, abort, or end of disconnect hold.
            W_DATA,
            R_DATA:  if (FRAME) next_state = TURN_AR;
            TURN_AR: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        DEVSEL = 1'b1;
        TRDY   = 1'b1;
        STOP   = 1'b1;
        AD_oe  = 1'b0;
        AD_out = '0;
        case (state)
            W_DATA: begin
                DEVSEL = 1'b0;
                TRDY   = disc;
                STOP   = !at_top;
            end
            R_TURN: begin
                DEVSEL = 1'b0;
                AD_oe  = 1'b1;
                AD_out = mem[ptr];
            end
            R_DATA: begin
                DEVSEL = 1'b0;
                TRDY   = disc;
                STOP   = !at_top;
                AD_oe  = 1'b1;
                AD_out = mem[ptr];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pci_target_responder.sv
// Directed bench for pci_target_responder: stimulus pushes expected read data into a
// scoreboard queue, a negedge monitor pops it on every read transfer.
module tb_pci_target_responder;

    logic        CLK   = 1'b0;
    logic        RST   = 1'b1;
    logic        FRAME = 1'b1;
    logic        IRDY  = 1'b1;
    logic        IDSEL = 1'b0;
    logic [31:0] AD_in = '0;
    logic [3:0]  CBE   = '0;
    logic [31:0] AD_out;
    logic        AD_oe;
    logic        DEVSEL;
    logic        TRDY;
    logic        STOP;

    int checks   = 0;
    int errors   = 0;
    int xfer_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] wd[8];
    logic [3:0]  wbe[8];
    logic [31:0] rd_exp[8];

    pci_target_responder dut (
        .CLK    (CLK),
        .RST    (RST),
        .FRAME  (FRAME),
        .IRDY   (IRDY),
        .IDSEL  (IDSEL),
        .AD_in  (AD_in),
        .CBE    (CBE),
        .AD_out (AD_out),
        .AD_oe  (AD_oe),
        .DEVSEL (DEVSEL),
        .TRDY   (TRDY),
        .STOP   (STOP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge-to-be with IRDY=0 && TRDY=0 is a transfer; read ones are scored.
    always @(negedge CLK) begin
        if (TRDY === 1'b0 && IRDY === 1'b0) begin
            xfer_cnt++;
            if (AD_oe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: actual %h required no read transfer at %0t", AD_out, $time);
                end else begin
                    check("rd_data", AD_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic f, input logic i, input logic [31:0] ad, input logic [3:0] cbe);
        FRAME = f;
        IRDY  = i;
        AD_in = ad;
        CBE   = cbe;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
        #1;
    endtask

    task automatic check_idle_outs(input string name);
        check({name, "_devsel"}, DEVSEL, 1);
        check({name, "_trdy"},   TRDY,   1);
        check({name, "_stop"},   STOP,   1);
        check({name, "_ad_oe"},  AD_oe,  0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input int n, input int wait_at);
        int x0;
        x0 = xfer_cnt;
        drive(1'b0, 1'b1, addr, 4'b0111);
        smp(); check("wr_addr_devsel", DEVSEL, 1);
        tick();
        for (int k = 0; k < n; k++) begin
            if (k == wait_at) begin
                drive(1'b0, 1'b1, 32'h0, 4'hF);
                smp(); check("wr_wait_trdy", TRDY, 0); check("wr_wait_devsel", DEVSEL, 0);
                tick();
            end
            drive(k == n - 1, 1'b0, wd[k], wbe[k]);
            smp(); check("wr_devsel", DEVSEL, 0); check("wr_trdy", TRDY, 0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        smp(); check_idle_outs("wr_turn_ar"); check("wr_xfers", xfer_cnt - x0, n);
        tick();
    endtask

    task automatic read_burst(input logic [31:0] addr, input int n);
        drive(1'b0, 1'b1, addr, 4'b0110);
        smp(); check("rd_addr_devsel", DEVSEL, 1);
        tick();
        drive(n == 1, 1'b0, 32'h0, 4'h0);
        smp(); check("rd_turn_devsel", DEVSEL, 0); check("rd_turn_trdy", TRDY, 1);
        check("rd_turn_ad_oe", AD_oe, 1);
        tick();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(rd_exp[k]);
            drive(k == n - 1, 1'b0, 32'h0, 4'h0);
            smp(); check("rd_trdy", TRDY, 0); check("rd_consumed", exp_q.size(), 0);
            exp_q.delete();
            tick();
        end
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        smp(); check_idle_outs("rd_turn_ar");
        tick();
    endtask

    task automatic miss_txn(input logic [31:0] addr, input logic [3:0] cmd);
        drive(1'b0, 1'b1, addr, cmd);
        smp(); check_idle_outs("miss_addr");
        tick();
        drive(1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0);
        smp(); check_idle_outs("miss_d0");
        tick();
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 4'h0);
        smp(); check_idle_outs("miss_d1");
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        smp(); check_idle_outs("miss_end");
        tick();
    endtask

    initial begin
        tick(); tick();
        smp(); check_idle_outs("reset"); check("reset_ad_out", AD_out, 0);
        RST = 1'b0;
        tick();

        // Burst of four with an initiator wait before the third word.
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int k = 0; k < 8; k++) wbe[k] = 4'h0;
        write_burst(32'h0, 4, 2);
        rd_exp[0] = 32'h11; rd_exp[1] = 32'h22; rd_exp[2] = 32'h33; rd_exp[3] = 32'h44;
        read_burst(32'h0, 4);

        wd[0] = 32'hDEAD_BEEF;
        write_burst(32'h8, 1, -1);
        rd_exp[0] = 32'hDEAD_BEEF;
        read_burst(32'h8, 1);

        // Byte enables 1010 keep bytes 1 and 3 of DEADBEEF.
        IDSEL = 1'b1;
        wd[0] = 32'h1234_5678; wbe[0] = 4'b1010;
        write_burst(32'h8, 1, -1);
        wbe[0] = 4'h0;
        rd_exp[0] = 32'hDE34_BE78;
        read_burst(32'h8, 1);

        miss_txn(32'h0000_0100, 4'b0111);
        miss_txn(32'h0000_0008, 4'b0010);
        rd_exp[0] = 32'h11; rd_exp[1] = 32'h22; rd_exp[2] = 32'hDE34_BE78; rd_exp[3] = 32'h44;
        read_burst(32'h0, 4);

        // Fill words 4..7, then burst-read from word 6 with FRAME held low.
        wd[0] = 32'h55; wd[1] = 32'h66; wd[2] = 32'h77; wd[3] = 32'h88;
        write_burst(32'h10, 4, -1);
        drive(1'b0, 1'b1, 32'h18, 4'b0110);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        smp(); check("dc_turn_trdy", TRDY, 1);
        tick();
        exp_q.push_back(32'h77);
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        smp(); check("dc_w6_trdy", TRDY, 0); check("dc_w6_stop", STOP, 1);
        tick();
        exp_q.push_back(32'h88);
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        smp(); check("dc_w7_trdy", TRDY, 0); check("dc_w7_stop", STOP, 0);
        check("dc_consumed", exp_q.size(), 0);
        exp_q.delete();
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        smp(); check("dc_hold_stop", STOP, 0); check("dc_hold_trdy", TRDY, 1);
        check("dc_hold_devsel", DEVSEL, 0);
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        smp(); check("dc_hold2_stop", STOP, 0); check("dc_hold2_trdy", TRDY, 1);
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        smp(); check_idle_outs("dc_turn_ar");
        tick();
        smp(); check("dc_idle_devsel", DEVSEL, 1);
        tick();

        // Reset lands on the edge of the second write transfer.
        IDSEL = 1'b0;
        drive(1'b0, 1'b1, 32'h0, 4'b0111);
        tick();
        drive(1'b0, 1'b0, 32'hAAAA_AAAA, 4'h0);
        tick();
        drive(1'b0, 1'b0, 32'hBBBB_BBBB, 4'h0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        smp(); check_idle_outs("rst_mid"); check("rst_mid_ad_out", AD_out, 0);
        tick();
        for (int k = 0; k < 8; k++) rd_exp[k] = 32'h0;
        read_burst(32'h0, 8);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
